// File: rtl/segre_cache_data_assoc.sv
// N-way set-associative data array for the Segre L1 caches.
// Provides a byte/half/word access port with a registered read, plus a multi-beat line refill engine.
package segre_cache_pkg;
  localparam int unsigned WORD_SIZE = 32;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
endpackage

module segre_cache_data_assoc
  import segre_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned BUS_BYTES  = 4,
  localparam int unsigned INDEX_W   = $clog2(NUM_SETS),
  localparam int unsigned WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int unsigned OFFSET_W  = $clog2(LINE_BYTES),
  localparam int unsigned BEATS     = LINE_BYTES / BUS_BYTES,
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rsn_i,
  input  logic                      rd_req_i,
  input  logic                      wr_req_i,
  input  memop_data_type_e          data_type_i,
  input  logic [WORD_SIZE-1:0]      addr_i,
  input  logic [WAY_W-1:0]          way_i,
  input  logic [WORD_SIZE-1:0]      data_i,
  output logic [WORD_SIZE-1:0]      data_o,
  output logic                      rd_valid_o,
  output logic                      misaligned_o,
  input  logic                      fill_start_i,
  input  logic                      fill_beat_valid_i,
  input  logic [BUS_BYTES*8-1:0]    fill_beat_i,
  output logic [LINE_BYTES*8-1:0]   evict_line_o,
  output logic                      busy_o,
  output logic                      fill_done_o
);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                  r_state;
  logic [LINE_BYTES*8-1:0] r_data [NUM_SETS][NUM_WAYS];
  logic [INDEX_W-1:0]      r_idx;
  logic [WAY_W-1:0]        r_way;
  logic [CNT_W-1:0]        r_cnt;

  logic [OFFSET_W-1:0]     w_offset;
  logic [INDEX_W-1:0]      w_index;
  logic [LINE_BYTES*8-1:0] w_line;
  logic                    w_legal;
  logic [2:0]              w_nbytes;
  logic                    w_port_en;
  logic                    w_rd_ok;
  logic                    w_wr_ok;
  logic                    w_mis;
  logic [OFFSET_W-1:0]     w_boff;
  logic [WORD_SIZE-1:0]    w_rdata;
  logic [LINE_BYTES-1:0]   w_wmask;
  logic [LINE_BYTES*8-1:0] w_wline;
  logic                    w_unused;

  assign w_offset  = addr_i[OFFSET_W-1:0];
  assign w_index   = addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_line    = r_data[w_index][way_i];
  assign w_unused  = ^addr_i[WORD_SIZE-1:OFFSET_W+INDEX_W];

  always_comb begin
    w_legal  = 1'b0;
    w_nbytes = 3'd1;
    case (data_type_i)
      BYTE: begin w_legal = 1'b1;                 w_nbytes = 3'd1; end
      HALF: begin w_legal = ~addr_i[0];           w_nbytes = 3'd2; end
      WORD: begin w_legal = (addr_i[1:0] == 2'b00); w_nbytes = 3'd4; end
      default: begin w_legal = 1'b0;              w_nbytes = 3'd1; end
    endcase
  end

  // The port is frozen during a refill and in the cycle that starts one.
  assign w_port_en = (r_state == IDLE) && !fill_start_i;
  assign w_rd_ok   = w_port_en && rd_req_i && w_legal;
  assign w_wr_ok   = w_port_en && wr_req_i && w_legal;
  assign w_mis     = w_port_en && (rd_req_i || wr_req_i) && !w_legal;

  always_comb begin
    w_rdata = '0;
    w_wmask = '0;
    w_wline = '0;
    w_boff  = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      w_boff = w_offset + OFFSET_W'(b);
      if (b < 32'(w_nbytes)) begin
        w_rdata[b*8 +: 8]             = w_line[32'(w_boff)*8 +: 8];
        w_wmask[w_boff]               = 1'b1;
        w_wline[32'(w_boff)*8 +: 8]   = data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          r_data[s][w] <= '0;
      r_state      <= IDLE;
      r_idx        <= '0;
      r_way        <= '0;
      r_cnt        <= '0;
      data_o       <= '0;
      rd_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      evict_line_o <= '0;
      busy_o       <= 1'b0;
      fill_done_o  <= 1'b0;
    end else begin
      rd_valid_o   <= w_rd_ok;
      misaligned_o <= w_mis;
      fill_done_o  <= 1'b0;
      if (w_rd_ok) data_o <= w_rdata;
      if (w_wr_ok) begin
        for (int unsigned i = 0; i < LINE_BYTES; i++)
          if (w_wmask[i]) r_data[w_index][way_i][i*8 +: 8] <= w_wline[i*8 +: 8];
      end
      case (r_state)
        IDLE: begin
          if (fill_start_i) begin
            r_state      <= FILL;
            busy_o       <= 1'b1;
            r_idx        <= w_index;
            r_way        <= way_i;
            r_cnt        <= '0;
            evict_line_o <= w_line;
          end
        end
        FILL: begin
          if (fill_beat_valid_i) begin
            r_data[r_idx][r_way][32'(r_cnt)*BUS_BYTES*8 +: BUS_BYTES*8] <= fill_beat_i;
            if (r_cnt == CNT_W'(BEATS-1)) begin
              r_state     <= IDLE;
              busy_o      <= 1'b0;
              fill_done_o <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_cache_data_assoc.sv
// Scoreboard bench for segre_cache_data_assoc: stimulus pushes expected port events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_segre_cache_data_assoc;
  import segre_cache_pkg::*;

  logic             clk = 1'b0;
  logic             rsn;
  logic             rd_req, wr_req;
  memop_data_type_e dtype;
  logic [31:0]      addr;
  logic [0:0]       way;
  logic [31:0]      din;
  logic [31:0]      data_o;
  logic             rd_valid_o, misaligned_o;
  logic             fill_start, fill_beat_valid;
  logic [31:0]      fill_beat;
  logic [127:0]     evict_line_o;
  logic             busy_o, fill_done_o;

  always #5 clk = ~clk;

  segre_cache_data_assoc #(
    .NUM_SETS(16), .NUM_WAYS(2), .LINE_BYTES(16), .BUS_BYTES(4)
  ) dut (
    .clk_i(clk), .rsn_i(rsn),
    .rd_req_i(rd_req), .wr_req_i(wr_req), .data_type_i(dtype),
    .addr_i(addr), .way_i(way), .data_i(din),
    .data_o(data_o), .rd_valid_o(rd_valid_o), .misaligned_o(misaligned_o),
    .fill_start_i(fill_start), .fill_beat_valid_i(fill_beat_valid), .fill_beat_i(fill_beat),
    .evict_line_o(evict_line_o), .busy_o(busy_o), .fill_done_o(fill_done_o)
  );

  // kind bits: [0]=rd_valid, [1]=misaligned, [2]=fill_done
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [127:0] LINE55  = {16{8'h55}};
  localparam logic [127:0] LINESEQ = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_o === 1'b1 || misaligned_o === 1'b1 || fill_done_o === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got rd=%b mis=%b done=%b expected none",
                   rd_valid_o, misaligned_o, fill_done_o);
        end else begin
          e = q.pop_front();
          chk({e.name, "_kind"}, {125'd0, fill_done_o, misaligned_o, rd_valid_o}, {125'd0, e.kind});
          if (e.kind[0]) chk(e.name, {96'd0, data_o}, {96'd0, e.data});
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle_in();
    rd_req = 1'b0; wr_req = 1'b0; dtype = WORD; addr = '0; way = '0; din = '0;
    fill_start = 1'b0; fill_beat_valid = 1'b0; fill_beat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input string name, input memop_data_type_e dt, input logic [31:0] a,
                       input logic w, input logic [31:0] exp);
    exp_t e;
    e.kind = 3'b001; e.data = exp; e.name = name;
    q.push_back(e);
    rd_req = 1'b1; dtype = dt; addr = a; way = w;
    tick();
    idle_in();
  endtask

  task automatic do_wr(input memop_data_type_e dt, input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    wr_req = 1'b1; dtype = dt; addr = a; way = w; din = d;
    tick();
    idle_in();
  endtask

  task automatic do_bad(input string name, input logic r, input logic wq,
                        input memop_data_type_e dt, input logic [31:0] a, input logic w);
    exp_t e;
    e.kind = 3'b010; e.data = '0; e.name = name;
    q.push_back(e);
    rd_req = r; wr_req = wq; dtype = dt; addr = a; way = w; din = 32'hBEEFBEEF;
    tick();
    idle_in();
  endtask

  task automatic do_beat(input logic [31:0] d, input logic last);
    exp_t e;
    if (last) begin
      e.kind = 3'b100; e.data = '0; e.name = "fill_done";
      q.push_back(e);
    end
    fill_beat_valid = 1'b1; fill_beat = d;
    tick();
    idle_in();
  endtask

  initial begin : stim
    exp_t e;
    idle_in();
    rsn = 1'b0;
    repeat (3) tick();
    chk("rst_data_o", {96'd0, data_o}, 128'd0);
    chk("rst_rd_valid", {127'd0, rd_valid_o}, 128'd0);
    chk("rst_misaligned", {127'd0, misaligned_o}, 128'd0);
    chk("rst_evict", evict_line_o, 128'd0);
    chk("rst_busy", {127'd0, busy_o}, 128'd0);
    chk("rst_fill_done", {127'd0, fill_done_o}, 128'd0);
    rsn = 1'b1;
    tick();

    do_rd("rd_after_reset", WORD, 32'h00, 1'b0, 32'h0000_0000);

    do_wr(WORD, 32'h04, 1'b1, 32'hAABBCCDD);
    do_wr(HALF, 32'h06, 1'b1, 32'h0000_1122);
    do_rd("rd_merge_w1", WORD, 32'h04, 1'b1, 32'h1122CCDD);
    do_rd("rd_other_way", WORD, 32'h04, 1'b0, 32'h0000_0000);
    do_rd("rd_byte5", BYTE, 32'h05, 1'b1, 32'h0000_00CC);
    do_rd("rd_byte7_odd", BYTE, 32'h07, 1'b1, 32'h0000_0011);
    do_rd("rd_half6", HALF, 32'h06, 1'b1, 32'h0000_1122);

    do_bad("mis_half_wr", 1'b0, 1'b1, HALF, 32'h03, 1'b1);
    do_rd("rd_after_mis0", WORD, 32'h00, 1'b1, 32'h0000_0000);
    do_rd("rd_after_mis4", WORD, 32'h04, 1'b1, 32'h1122CCDD);
    do_bad("mis_word_rd", 1'b1, 1'b0, WORD, 32'h02, 1'b1);
    chk("data_hold", {96'd0, data_o}, {96'd0, 32'h1122CCDD});
    do_bad("illegal_type", 1'b1, 1'b0, memop_data_type_e'(2'b11), 32'h04, 1'b1);

    e.kind = 3'b001; e.data = 32'h0; e.name = "rd_before_wr";
    q.push_back(e);
    rd_req = 1'b1; wr_req = 1'b1; dtype = WORD; addr = 32'h08; way = 1'b1; din = 32'h12345678;
    tick();
    idle_in();
    do_rd("rd_after_rw", WORD, 32'h08, 1'b1, 32'h12345678);

    for (int i = 0; i < 4; i++) do_wr(WORD, 32'h20 + 32'(i*4), 1'b0, 32'h55555555);
    do_wr(WORD, 32'h20, 1'b1, 32'hDEADBEEF);

    // Refill start carries a read that must be dropped.
    fill_start = 1'b1; rd_req = 1'b1; dtype = WORD; addr = 32'h20; way = 1'b0;
    tick();
    idle_in();
    chk("fill_busy", {127'd0, busy_o}, 128'd1);
    chk("fill_evict", evict_line_o, LINE55);
    do_beat(32'h03020100, 1'b0);
    do_beat(32'h07060504, 1'b0);
    wr_req = 1'b1; dtype = WORD; addr = 32'h24; way = 1'b0; din = 32'hFFFFFFFF;
    tick();
    idle_in();
    do_beat(32'h0B0A0908, 1'b0);
    fill_start = 1'b1; addr = 32'h30; way = 1'b1;
    tick();
    idle_in();
    chk("evict_after_2nd_start", evict_line_o, LINE55);
    chk("busy_mid_fill", {127'd0, busy_o}, 128'd1);
    do_beat(32'h0F0E0D0C, 1'b1);
    chk("busy_after_fill", {127'd0, busy_o}, 128'd0);

    fill_beat_valid = 1'b1; fill_beat = 32'hFFFFFFFF;
    tick();
    idle_in();

    do_rd("fill_rd20", WORD, 32'h20, 1'b0, 32'h03020100);
    do_rd("fill_rd24", WORD, 32'h24, 1'b0, 32'h07060504);
    do_rd("fill_rd28", WORD, 32'h28, 1'b0, 32'h0B0A0908);
    do_rd("fill_rd2c", WORD, 32'h2C, 1'b0, 32'h0F0E0D0C);
    do_rd("fill_other_way", WORD, 32'h20, 1'b1, 32'hDEADBEEF);
    do_rd("fill_set3_untouched", WORD, 32'h30, 1'b1, 32'h0000_0000);
    chk("evict_hold", evict_line_o, LINE55);

    fill_start = 1'b1; addr = 32'h20; way = 1'b0;
    tick();
    idle_in();
    chk("evict_seq_line", evict_line_o, LINESEQ);
    do_beat(32'hA0A0A0A0, 1'b0);
    do_beat(32'hB0B0B0B0, 1'b0);
    rsn = 1'b0;
    tick();
    chk("midrst_busy", {127'd0, busy_o}, 128'd0);
    chk("midrst_evict", evict_line_o, 128'd0);
    rsn = 1'b1;
    repeat (3) tick();
    do_rd("midrst_rd04w1", WORD, 32'h04, 1'b1, 32'h0);
    do_rd("midrst_rd08w1", WORD, 32'h08, 1'b1, 32'h0);
    do_rd("midrst_rd20w0", WORD, 32'h20, 1'b0, 32'h0);
    do_rd("midrst_rd2cw0", WORD, 32'h2C, 1'b0, 32'h0);
    do_rd("midrst_rd20w1", WORD, 32'h20, 1'b1, 32'h0);

    repeat (3) tick();
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/segre_cache_data_assoc.md
Name: segre_cache_data_assoc

Overview:
Parametrised N-way set-associative data array for the Segre L1 caches; successor to the direct-mapped data store. It provides word/half/byte reads and writes with alignment checking, a one-cycle registered read port, and a multi-beat line refill engine. At refill start it captures the victim line for write-back. It sits between the cache controller (tag/LRU logic supplies the way) and the memory interface.

Parameters:
NUM_SETS, 16, number of sets (power of two, >=2); INDEX_W = clog2(NUM_SETS)
NUM_WAYS, 2, associativity (power of two, >=1); WAY_W = max(1, clog2(NUM_WAYS))
LINE_BYTES, 16, bytes per line (power of two, >=4); OFFSET_W = clog2(LINE_BYTES)
BUS_BYTES, 4, refill beat width in bytes (power of two, divides LINE_BYTES); BEATS = LINE_BYTES/BUS_BYTES

Ports:
clk_i  in  1  clock, all state on rising edge
rsn_i  in  1  reset, synchronous, active-low
rd_req_i  in  1  word-port read request
wr_req_i  in  1  word-port write request
data_type_i  in  memop_data_type_e  access size: BYTE / HALF / WORD
addr_i  in  WORD_SIZE  byte address; offset = [OFFSET_W-1:0], index = [OFFSET_W+INDEX_W-1:OFFSET_W]
way_i  in  WAY_W  selected way for word access or fill
data_i  in  WORD_SIZE  store data, LSB-aligned
data_o  out  WORD_SIZE  read data, zero-extended, LSB-aligned
rd_valid_o  out  1  data_o valid (1-cycle pulse)
misaligned_o  out  1  1-cycle pulse: rejected misaligned/illegal access
fill_start_i  in  1  begin refill of set addr_i index, way way_i
fill_beat_valid_i  in  1  refill beat present
fill_beat_i  in  BUS_BYTES*8  refill beat data, byte 0 in bits [7:0]
evict_line_o  out  LINE_BYTES*8  victim line captured at fill start
busy_o  out  1  refill in progress
fill_done_o  out  1  1-cycle pulse after last beat written

Behaviour:
- Reset (rsn_i=0 at edge): all array bytes = 0; data_o=0, rd_valid_o=0, misaligned_o=0, evict_line_o=0, busy_o=0, fill_done_o=0, beat counter=0, FSM=IDLE. Reset asserted mid-fill aborts the fill; no fill_done_o.
- FSM states: IDLE, FILL.
- IDLE -> FILL: on fill_start_i. Latch index and way. Register evict_line_o = current contents of array[index][way] (pre-fill). busy_o=1 from the next cycle. Counter = 0.
- FILL: on each fill_beat_valid_i, write fill_beat_i to bytes [cnt*BUS_BYTES +: BUS_BYTES] of the latched line, then cnt++. When the beat with cnt==BEATS-1 is accepted, the next cycle shows busy_o=0, fill_done_o=1, FSM=IDLE, cnt=0. Gaps between beats are allowed.
- fill_start_i while in FILL is ignored. fill_beat_valid_i in IDLE is ignored. evict_line_o holds until the next fill_start_i.
- Word port is served only in IDLE and not in the fill_start_i cycle. Requests while busy_o=1 or fill_start_i=1 are dropped: no write, no rd_valid_o, no misaligned_o.
- Alignment: HALF requires addr_i[0]=0; WORD requires addr_i[1:0]=0. BYTE is always legal. Any other data_type_i value is illegal.
- Misaligned or illegal request (rd or wr): no array change; misaligned_o=1 next cycle; rd_valid_o stays 0.
- Read: 1-cycle latency. The cycle after a legal rd_req_i: rd_valid_o=1, data_o = selected bytes, little-endian, upper bits zero.
- data_o holds its last value when rd_valid_o=0.
- Write: a legal wr_req_i updates only the 1/2/4 addressed bytes of array[index][way_i] at the edge.
- rd_req_i and wr_req_i together, legal: the write is performed and the read returns pre-write data (read-before-write).
- Only the addressed way is touched; other ways of the same set are unchanged.

Test Plan:
- Reset then read: WORD read of addr 0x00, way 0 -> next cycle rd_valid_o=1, data_o=0x00000000.
- Byte-granular write: WORD write 0xAABBCCDD to 0x04 way 1, then HALF write 0x1122 to 0x06 way 1, then WORD read 0x04 way 1 -> data_o=0x1122CCDD. Same address in way 0 still reads 0.
- Misalignment: HALF write to 0x03 -> misaligned_o pulses next cycle, array unchanged. WORD read 0x02 -> misaligned_o=1, rd_valid_o=0.
- Refill: set 2 way 0 preloaded with 0x55 bytes; fill_start_i addr 0x20; beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with one idle cycle between beats 2 and 3. Required: evict_line_o = all 0x55; fill_done_o one cycle after beat 4; WORD read 0x2C -> 0x0F0E0D0C.
- Busy drop: wr_req_i during FILL -> ignored, target line unchanged after fill. A second fill_start_i during FILL is ignored.
- Reset mid-fill: assert rsn_i=0 after beat 2 -> busy_o=0, no fill_done_o, all lines read 0.
